// File: rtl/song_recorder.sv
// Multi-slot note recorder/player: records the live key stream per step tick, plays a slot back.
// Live path 1 clk; play outputs change 1 clk after a step tick; no backpressure, switches are levels.
module song_recorder #(
  parameter int SLOTS      = 3,
  parameter int DEPTH      = 256,
  parameter int STEP_DIV   = 5_000_000,
  parameter int CLEAR_HOLD = 10,
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rec_en,
  input  logic          play_en,
  input  logic          loop,
  input  logic          clear,
  input  logic [SW-1:0] play_slot,
  input  logic [6:0]    keys,
  input  logic [1:0]    octave,
  output logic [3:0]    live_note,
  output logic [1:0]    live_octave,
  output logic [6:0]    live_led,
  output logic [3:0]    play_note,
  output logic [1:0]    play_octave,
  output logic [6:0]    play_led,
  output logic [1:0]    state,
  output logic [SW-1:0] rec_slot,
  output logic          full,
  output logic          play_done,
  output logic          cleared
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STEP_DIV);
  localparam int HW = $clog2(CLEAR_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } state_e;

  function automatic logic [3:0] key_to_note(input logic [6:0] k);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 7; i++) begin
      if (k == (7'd1 << i)) n = 4'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [6:0] note_to_led(input logic [3:0] n);
    logic [6:0] l;
    l = 7'd0;
    for (int i = 0; i < 7; i++) begin
      if (n == 4'(i + 1)) l[i] = 1'b1;
    end
    return l;
  endfunction

  state_e        state_q, state_d;
  logic [SW-1:0] rec_slot_q, rec_slot_d;
  logic [SW-1:0] pslot_q, pslot_d;
  logic [LW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] plen_q, plen_d;
  logic [LW-1:0] len_q [SLOTS];
  logic [LW-1:0] len_d [SLOTS];
  logic [CW-1:0] div_q, div_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rec_prev_q, play_prev_q;
  logic [3:0]    live_note_q;
  logic [1:0]    live_oct_q;
  logic [6:0]    live_led_q;
  logic [3:0]    play_note_q, play_note_d;
  logic [1:0]    play_oct_q, play_oct_d;
  logic [6:0]    play_led_q;
  logic          play_done_q, play_done_d;
  logic          cleared_q;

  // Song storage, one {note, octave} word per step; intentionally not reset.
  logic [5:0]    mem [SLOTS][DEPTH];

  logic          tick, rec_rise, play_rise, slot_ok, clear_fire, mem_we;
  logic [AW-1:0] rd_idx;
  logic [5:0]    rd_word;

  assign tick       = (div_q == CW'(STEP_DIV - 1));
  assign rec_rise   = rec_en & ~rec_prev_q;
  assign play_rise  = play_en & ~play_prev_q;
  assign slot_ok    = (int'(play_slot) < SLOTS);
  assign clear_fire = tick & clear & (hold_q == HW'(CLEAR_HOLD - 1));
  // Wrapping back to step 0 on a loop reads the first word in the same tick.
  assign rd_idx     = (rptr_q == plen_q) ? '0 : rptr_q[AW-1:0];
  assign rd_word    = mem[pslot_q][rd_idx];

  always_comb begin
    state_d     = state_q;
    rec_slot_d  = rec_slot_q;
    pslot_d     = pslot_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    plen_d      = plen_q;
    len_d       = len_q;
    play_note_d = play_note_q;
    play_oct_d  = play_oct_q;
    play_done_d = 1'b0;
    mem_we      = 1'b0;
    div_d       = tick ? '0 : div_q + CW'(1);

    if (!clear) begin
      hold_d = '0;
    end else if (tick && (hold_q != HW'(CLEAR_HOLD))) begin
      hold_d = hold_q + HW'(1);
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rec_rise) begin
          state_d = S_REC;
          wptr_d  = '0;
        end else if (play_rise && slot_ok) begin
          state_d = S_PLAY;
          pslot_d = play_slot;
          rptr_d  = '0;
          plen_d  = len_q[play_slot];
        end
      end
      S_REC: begin
        if (!rec_en) begin
          len_d[rec_slot_q] = wptr_q;
          rec_slot_d        = (rec_slot_q == SW'(SLOTS - 1)) ? '0 : rec_slot_q + SW'(1);
          state_d           = S_IDLE;
        end else if (tick && (wptr_q < LW'(DEPTH))) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + LW'(1);
        end
      end
      S_PLAY: begin
        if (!play_en) begin
          state_d     = S_IDLE;
          play_note_d = 4'd0;
          play_oct_d  = 2'd0;
        end else if (plen_q == '0) begin
          state_d     = S_IDLE;
          play_done_d = 1'b1;
          play_note_d = 4'd0;
          play_oct_d  = 2'd0;
        end else if (tick) begin
          if ((rptr_q == plen_q) && !loop) begin
            state_d     = S_IDLE;
            play_done_d = 1'b1;
            play_note_d = 4'd0;
            play_oct_d  = 2'd0;
          end else begin
            play_note_d = rd_word[5:2];
            play_oct_d  = rd_word[1:0];
            rptr_d      = LW'(rd_idx) + LW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Playback uses its own latched length, so a clear never disturbs it.
    if (clear_fire) begin
      len_d[rec_slot_q] = '0;
      if (state_q == S_REC) wptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rec_slot_q  <= '0;
      pslot_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      plen_q      <= '0;
      for (int i = 0; i < SLOTS; i++) len_q[i] <= '0;
      div_q       <= '0;
      hold_q      <= '0;
      rec_prev_q  <= 1'b0;
      play_prev_q <= 1'b0;
      live_note_q <= 4'd0;
      live_oct_q  <= 2'd0;
      live_led_q  <= 7'd0;
      play_note_q <= 4'd0;
      play_oct_q  <= 2'd0;
      play_led_q  <= 7'd0;
      play_done_q <= 1'b0;
      cleared_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rec_slot_q  <= rec_slot_d;
      pslot_q     <= pslot_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      plen_q      <= plen_d;
      len_q       <= len_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      rec_prev_q  <= rec_en;
      play_prev_q <= play_en;
      live_note_q <= key_to_note(keys);
      live_oct_q  <= octave;
      live_led_q  <= note_to_led(key_to_note(keys));
      play_note_q <= play_note_d;
      play_oct_q  <= play_oct_d;
      play_led_q  <= note_to_led(play_note_d);
      play_done_q <= play_done_d;
      cleared_q   <= clear_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[rec_slot_q][wptr_q[AW-1:0]] <= {live_note_q, live_oct_q};
  end

  assign live_note   = live_note_q;
  assign live_octave = live_oct_q;
  assign live_led    = live_led_q;
  assign play_note   = play_note_q;
  assign play_octave = play_oct_q;
  assign play_led    = play_led_q;
  assign state       = state_q;
  assign rec_slot    = rec_slot_q;
  assign full        = (state_q == S_REC) && (wptr_q == LW'(DEPTH));
  assign play_done   = play_done_q;
  assign cleared     = cleared_q;

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder with SLOTS=3, DEPTH=8, STEP_DIV=4, CLEAR_HOLD=3.
module tb_song_recorder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rec_en, play_en, loop_en, clear;
  logic [1:0] play_slot;
  logic [6:0] keys;
  logic [1:0] octave;
  logic [3:0] live_note, play_note;
  logic [1:0] live_octave, play_octave, state, rec_slot;
  logic [6:0] live_led, play_led;
  logic       full, play_done, cleared;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  // Mirrors the free-running step divider: the edge taken while cyc%4==3 is a tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  song_recorder #(.SLOTS(3), .DEPTH(8), .STEP_DIV(4), .CLEAR_HOLD(3)) dut (
    .clk(clk), .reset(rst_n), .rec_en(rec_en), .play_en(play_en), .loop(loop_en),
    .clear(clear), .play_slot(play_slot), .keys(keys), .octave(octave),
    .live_note(live_note), .live_octave(live_octave), .live_led(live_led),
    .play_note(play_note), .play_octave(play_octave), .play_led(play_led),
    .state(state), .rec_slot(rec_slot), .full(full), .play_done(play_done), .cleared(cleared)
  );

  function automatic logic [6:0] led_of(input int n);
    return (n == 0) ? 7'd0 : 7'(1 << (n - 1));
  endfunction

  function automatic int full_note(input int i);
    return (i <= 7) ? 8 - i : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit t;
    do begin
      t = (cyc % 4 == 3);
      step();
    end while (!t);
  endtask

  task automatic set_key(input int n, input int o);
    keys   = led_of(n);
    octave = 2'(o);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rec_en = 0; play_en = 0; loop_en = 0; clear = 0;
    play_slot = 2'd0; keys = 7'd0; octave = 2'd0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({state, rec_slot, full, play_done, cleared} !== 7'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {state, rec_slot, full, play_done, cleared});
    end
    checks++;
    if ({live_note, live_octave, live_led, play_note, play_octave, play_led} !== 26'd0) begin
      failures++; $display("FAIL reset_notes got=%h exp=0", {live_note, live_octave, live_led, play_note, play_octave, play_led});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_live();
    keys = 7'b0000100; octave = 2'd2; step();
    checks++;
    if ({live_note, live_octave, live_led} !== {4'd3, 2'd2, 7'b0000100}) begin
      failures++; $display("FAIL live_onehot got=%h exp=%h", {live_note, live_octave, live_led}, {4'd3, 2'd2, 7'b0000100});
    end
    keys = 7'b0000101; step();
    checks++;
    if ({live_note, live_octave, live_led} !== {4'd0, 2'd2, 7'd0}) begin
      failures++; $display("FAIL live_multihot got=%h exp=%h", {live_note, live_octave, live_led}, {4'd0, 2'd2, 7'd0});
    end
    keys = 7'b1000000; octave = 2'd1; step();
    checks++;
    if ({live_note, live_octave, live_led} !== {4'd7, 2'd1, 7'b1000000}) begin
      failures++; $display("FAIL live_key7 got=%h exp=%h", {live_note, live_octave, live_led}, {4'd7, 2'd1, 7'b1000000});
    end
  endtask

  task automatic test_record_play();
    wait_tick();
    rec_en = 1; set_key(1, 1); step();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL rec_enter state=%0d exp=1", state); end
    wait_tick();
    for (int n = 2; n <= 5; n++) begin
      set_key(n, n % 4);
      wait_tick();
    end
    rec_en = 0; step();
    checks++;
    if ({state, rec_slot} !== {2'd0, 2'd1}) begin
      failures++; $display("FAIL rec_exit state/slot=%b exp=%b", {state, rec_slot}, {2'd0, 2'd1});
    end
    play_slot = 2'd0; loop_en = 0; play_en = 1; step();
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL play_enter state=%0d exp=2", state); end
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      checks++;
      if ({play_note, play_octave, play_led} !== {4'(k), 2'(k % 4), led_of(k)}) begin
        failures++; $display("FAIL play_step%0d got=%h exp=%h", k, {play_note, play_octave, play_led}, {4'(k), 2'(k % 4), led_of(k)});
      end
    end
    step();
    checks++;
    if (play_note !== 4'd5) begin failures++; $display("FAIL play_hold note=%0d exp=5", play_note); end
    wait_tick();
    checks++;
    if ({state, play_done, play_note, play_led} !== {2'd0, 1'b1, 4'd0, 7'd0}) begin
      failures++; $display("FAIL play_end got=%h exp=%h", {state, play_done, play_note, play_led}, {2'd0, 1'b1, 4'd0, 7'd0});
    end
    step();
    checks++;
    if (play_done !== 1'b0) begin failures++; $display("FAIL play_done_pulse got=%b exp=0", play_done); end
    play_en = 0; step();
  endtask

  task automatic test_full_loop();
    wait_tick();
    rec_en = 1; set_key(full_note(1), 1); step();
    wait_tick();
    for (int i = 2; i <= 12; i++) begin
      set_key(full_note(i), i % 4);
      wait_tick();
      if (i == 7) begin
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL full_early got=%b exp=0", full); end
      end
      if (i == 8 || i == 12) begin
        checks++;
        if (full !== 1'b1) begin failures++; $display("FAIL full_at%0d got=%b exp=1", i, full); end
      end
    end
    rec_en = 0; step();
    checks++;
    if ({state, rec_slot, full} !== {2'd0, 2'd2, 1'b0}) begin
      failures++; $display("FAIL full_exit got=%b exp=%b", {state, rec_slot, full}, {2'd0, 2'd2, 1'b0});
    end
    play_slot = 2'd1; loop_en = 1; play_en = 1; step();
    for (int k = 1; k <= 10; k++) begin
      int i;
      i = ((k - 1) % 8) + 1;
      wait_tick();
      checks++;
      if ({state, play_note, play_octave} !== {2'd2, 4'(full_note(i)), 2'(i % 4)}) begin
        failures++; $display("FAIL loop_tick%0d got=%h exp=%h", k, {state, play_note, play_octave}, {2'd2, 4'(full_note(i)), 2'(i % 4)});
      end
    end
    play_en = 0; step();
    checks++;
    if ({state, play_note, play_octave, play_led, play_done} !== {2'd0, 13'd0, 1'b0}) begin
      failures++; $display("FAIL play_abort got=%h exp=0", {state, play_note, play_octave, play_led, play_done});
    end
    loop_en = 0;
  endtask

  task automatic test_slot_wrap();
    wait_tick();
    rec_en = 1; step();
    rec_en = 0; step();
    checks++;
    if ({state, rec_slot} !== {2'd0, 2'd0}) begin
      failures++; $display("FAIL slot_wrap got=%b exp=%b", {state, rec_slot}, 4'd0);
    end
    play_slot = 2'd2; play_en = 1; step();
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL empty_enter state=%0d exp=2", state); end
    step();
    checks++;
    if ({state, play_done, play_note} !== {2'd0, 1'b1, 4'd0}) begin
      failures++; $display("FAIL empty_done got=%b exp=%b", {state, play_done, play_note}, {2'd0, 1'b1, 4'd0});
    end
    step();
    checks++;
    if (play_done !== 1'b0) begin failures++; $display("FAIL empty_pulse got=%b exp=0", play_done); end
    play_en = 0; step();
    play_slot = 2'd3; play_en = 1; step();
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL bad_slot state=%0d exp=0", state); end
    play_en = 0; step();
  endtask

  task automatic test_clear();
    wait_tick();
    rec_en = 1; set_key(1, 0); step();
    repeat (4) wait_tick();
    clear = 1;
    for (int t = 5; t <= 6; t++) begin
      wait_tick();
      checks++;
      if (cleared !== 1'b0) begin failures++; $display("FAIL clear_early%0d got=%b exp=0", t, cleared); end
    end
    wait_tick();
    checks++;
    if ({cleared, full, state} !== {1'b1, 1'b0, 2'd1}) begin
      failures++; $display("FAIL clear_fire got=%b exp=%b", {cleared, full, state}, {1'b1, 1'b0, 2'd1});
    end
    set_key(3, 1); step();
    checks++;
    if (cleared !== 1'b0) begin failures++; $display("FAIL clear_pulse got=%b exp=0", cleared); end
    wait_tick();
    checks++;
    if (cleared !== 1'b0) begin failures++; $display("FAIL clear_refire1 got=%b exp=0", cleared); end
    set_key(4, 2);
    wait_tick();
    checks++;
    if (cleared !== 1'b0) begin failures++; $display("FAIL clear_refire2 got=%b exp=0", cleared); end
    rec_en = 0; clear = 0; step();
    checks++;
    if (rec_slot !== 2'd1) begin failures++; $display("FAIL clear_slot got=%0d exp=1", rec_slot); end
    play_slot = 2'd0; play_en = 1; step();
    wait_tick();
    checks++;
    if ({play_note, play_octave} !== {4'd3, 2'd1}) begin
      failures++; $display("FAIL clear_play1 got=%h exp=%h", {play_note, play_octave}, {4'd3, 2'd1});
    end
    wait_tick();
    checks++;
    if ({play_note, play_octave} !== {4'd4, 2'd2}) begin
      failures++; $display("FAIL clear_play2 got=%h exp=%h", {play_note, play_octave}, {4'd4, 2'd2});
    end
    wait_tick();
    checks++;
    if ({state, play_done, play_note} !== {2'd0, 1'b1, 4'd0}) begin
      failures++; $display("FAIL clear_len got=%b exp=%b", {state, play_done, play_note}, {2'd0, 1'b1, 4'd0});
    end
    play_en = 0; step();
  endtask

  task automatic test_back_to_back();
    rec_en = 1; play_en = 1; step();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL simul_edge state=%0d exp=1", state); end
    rec_en = 0; play_en = 0; step();
    checks++;
    if ({state, rec_slot} !== {2'd0, 2'd2}) begin
      failures++; $display("FAIL simul_exit got=%b exp=%b", {state, rec_slot}, {2'd0, 2'd2});
    end
  endtask

  task automatic test_reset_mid_play();
    play_slot = 2'd0; loop_en = 1; play_en = 1; step();
    wait_tick();
    checks++;
    if (play_note !== 4'd3) begin failures++; $display("FAIL pre_reset note=%0d exp=3", play_note); end
    keys = 7'b1000000; step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, rec_slot, full, play_done, cleared} !== 7'd0) begin
      failures++; $display("FAIL async_reset_ctrl got=%b exp=0", {state, rec_slot, full, play_done, cleared});
    end
    checks++;
    if ({live_note, live_octave, live_led, play_note, play_octave, play_led} !== 26'd0) begin
      failures++; $display("FAIL async_reset_notes got=%h exp=0", {live_note, live_octave, live_led, play_note, play_octave, play_led});
    end
    play_en = 0; loop_en = 0; keys = 7'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    play_en = 1; step();
    step();
    checks++;
    if ({state, play_done} !== {2'd0, 1'b1}) begin
      failures++; $display("FAIL len_reset got=%b exp=%b", {state, play_done}, {2'd0, 1'b1});
    end
    play_en = 0; step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_live();
    test_record_play();
    test_full_loop();
    test_slot_wrap();
    test_clear();
    test_back_to_back();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/song_recorder.md
# song_recorder

Parametrised multi-slot note recorder/player for the piano datapath. Captures the live key/octave stream into one of `SLOTS` song buffers at a fixed step rate and plays any slot back with per-slot recorded length, optional looping and long-press clear. It also drives the registered live-note path to the tone generator, and sits between the key/switch decode and the buzzer/LED output mux.

## Interface
Parameters:
- `SLOTS`, 3: number of song buffers, ≥1. `SW = max(1, $clog2(SLOTS))`.
- `DEPTH`, 256: steps per slot, ≥2. `LW = $clog2(DEPTH+1)`.
- `STEP_DIV`, 5_000_000: clk cycles per step tick, ≥2.
- `CLEAR_HOLD`, 10: consecutive step ticks with `clear` high that trigger a clear, ≥1.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `rec_en`, in, 1: record switch (level).
- `play_en`, in, 1: play switch (level).
- `loop`, in, 1: loop playback at end of slot.
- `clear`, in, 1: clear button (level).
- `play_slot`, in, SW: slot to play. Sampled at play start.
- `keys`, in, 7: note keys.
- `octave`, in, 2: octave switches.
- `live_note`, out, 4; `live_octave`, out, 2; `live_led`, out, 7: registered live path.
- `play_note`, out, 4; `play_octave`, out, 2; `play_led`, out, 7: playback path.
- `state`, out, 2: 0 IDLE, 1 REC, 2 PLAY.
- `rec_slot`, out, SW: slot the next or current recording targets.
- `full`, out, 1: high in REC once DEPTH steps are written.
- `play_done`, out, 1: one-cycle pulse at non-loop end of playback.
- `cleared`, out, 1: one-cycle pulse when a clear executes.

## Operation
- Key decode: one-hot `keys` bit i gives note i+1 and LED = `keys`. Zero or multi-hot keys give note 0 (rest) and LED 0.
- Memory word per step is {note[3:0], octave[1:0]}. LED is regenerated from the note on read (note n gives bit n-1; rest gives 0). `len[SLOTS]` is LW bits wide and resets to 0.
- Step tick: a free-running counter asserts `tick` for one clk when it reaches STEP_DIV-1, then wraps to 0. The counter runs in all states.
- IDLE:
  - A rising edge of `rec_en` enters REC and sets wptr=0.
  - Otherwise a rising edge of `play_en` enters PLAY with slot latched from `play_slot` and rptr=0. If `len[slot]==0`, the block returns to IDLE the next cycle and pulses `play_done`.
  - `play_slot` ≥ SLOTS is ignored (no start).
- REC:
  - On each tick with wptr<DEPTH: write mem[rec_slot][wptr] and increment wptr.
  - `full` is high when wptr==DEPTH. Further ticks are ignored.
  - `rec_en` low: `len[rec_slot]` gets wptr, `rec_slot` advances (wrapping from SLOTS-1 to 0), return to IDLE.
  - `play_en` is ignored while in REC.
- PLAY:
  - On each tick: output mem[slot][rptr] on the play outputs and increment rptr.
  - After emitting the last step (rptr reaches len): if `loop`, rptr=0 and play continues. Else go to IDLE, pulse `play_done`, and set the play outputs to rest.
  - `play_en` low in PLAY: return to IDLE immediately and set the play outputs to rest.
- Clear:
  - The hold counter increments on ticks while `clear` is high. It resets to 0 whenever `clear` is low and saturates at CLEAR_HOLD.
  - On reaching CLEAR_HOLD, one clear fires and `cleared` pulses. It does not fire again until `clear` is released.
  - A clear sets `len[rec_slot]=0`. In REC it also sets wptr=0 and drops `full`.
  - A clear in PLAY has no effect on playback.
- Simultaneous rising edges of `rec_en` and `play_en` in IDLE: REC wins.

## Timing
- Reset values: state IDLE; `rec_slot` 0; all `len` 0; counters 0; all note/octave/led outputs 0; `full`, `play_done`, `cleared` 0.
- Memory contents are not reset.
- Live path latency: 1 clk from `keys`/`octave` to `live_*`.
- Edge detection uses a registered prior value, so state changes 1 clk after the switch edge.
- Memory writes occur on the tick edge.
- Play outputs update on the clk after a tick and hold until the next tick.
- Reset mid-REC: `len` for that slot stays 0 and `rec_slot` does not advance.

## Test plan
Bench parameters: SLOTS=3, DEPTH=8, STEP_DIV=4, CLEAR_HOLD=3.
- Reset then `keys`=7'b0000100, `octave`=2 -> next clk `live_note`=3, `live_led`=7'b0000100. Then `keys`=7'b0000101 -> `live_note`=0, `live_led`=0.
- Record 5 ticks of notes 1,2,3,4,5 into slot 0, drop `rec_en` -> `rec_slot`=1. Play slot 0 without loop -> `play_note` 1..5 on consecutive ticks, then `play_done` pulse and `play_note`=0.
- Record 12 ticks into slot 1 -> `full` high after 8th tick, `len`=8. Playback emits 8 steps. With `loop`=1, step 9 equals step 1.
- Three recordings -> `rec_slot` sequence 1,2,0. Play slot 2 with `len` 0 -> `play_done` 1 clk after entry, no tick output.
- In REC after 4 ticks, hold `clear` for 3 ticks -> `cleared` pulse, wptr 0. Release `rec_en` after 2 more ticks -> `len`=2. Holding `clear` longer produces no second pulse.
- `rec_en` and `play_en` rise in the same clk -> `state`=REC. Drop `play_en` mid-PLAY -> IDLE next clk with play outputs 0. Assert reset mid-PLAY -> all outputs 0 asynchronously.
